// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the TMDS lane encoder.
// Mode codes, fixed symbols, the TERC4 table and a popcount.
package tmds_pkg;

  localparam logic [2:0] MODE_CTRL    = 3'd0;
  localparam logic [2:0] MODE_VIDEO   = 3'd1;
  localparam logic [2:0] MODE_VGUARD  = 3'd2;
  localparam logic [2:0] MODE_DISLAND = 3'd3;
  localparam logic [2:0] MODE_DGUARD  = 3'd4;

  localparam logic [9:0] CTRL_SYM_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_SYM_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_SYM_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_SYM_11 = 10'b1010101011;

  localparam logic [9:0] GUARD_EVEN = 10'b1011001100;
  localparam logic [9:0] GUARD_ODD  = 10'b0100110011;

  // Control pair {c1,c0} to its fixed symbol.
  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = CTRL_SYM_00;
      2'b01:   s = CTRL_SYM_01;
      2'b10:   s = CTRL_SYM_10;
      default: s = CTRL_SYM_11;
    endcase
    return s;
  endfunction

  // TERC4 nibble to 10-bit data-island symbol.
  function automatic logic [9:0] terc4_sym(input logic [3:0] n);
    logic [9:0] s;
    case (n)
      4'h0:    s = 10'b1010011100;
      4'h1:    s = 10'b1001100011;
      4'h2:    s = 10'b1011100100;
      4'h3:    s = 10'b1011100010;
      4'h4:    s = 10'b0101110001;
      4'h5:    s = 10'b0100011110;
      4'h6:    s = 10'b0110001110;
      4'h7:    s = 10'b0100111100;
      4'h8:    s = 10'b1011001100;
      4'h9:    s = 10'b0100111001;
      4'hA:    s = 10'b0110011100;
      4'hB:    s = 10'b1011000110;
      4'hC:    s = 10'b1010001110;
      4'hD:    s = 10'b1001110001;
      4'hE:    s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  // Number of ones in a byte.
  function automatic logic [3:0] popcnt8(input logic [7:0] d);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, d[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/tmds_lane.sv
// Single-lane 2-stage TMDS encoder.
// Stage 1 builds q_m; stage 2 balances and muxes by period mode.
module tmds_lane
  import tmds_pkg::*;
#(
  parameter int LANE_IDX = 0
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_ce,
  input  logic [2:0] I_mode,
  input  logic [7:0] I_data,
  input  logic [1:0] I_ctrl,
  input  logic [3:0] I_terc4,
  output logic [9:0] O_tmds
);

  localparam logic [9:0] LANE_GUARD =
    (LANE_IDX % 2 == 1) ? GUARD_ODD : GUARD_EVEN;

  logic [3:0] w_n1d;
  logic       w_xnor;
  logic [8:0] w_qm;
  logic [3:0] w_n1q;

  logic [8:0] r_qm;
  logic [3:0] r_n1;
  logic [3:0] r_n0;
  logic [2:0] r_mode1;
  logic [1:0] r_ctrl1;
  logic [3:0] r_terc41;

  logic [9:0] r_out;
  logic [4:0] r_cnt;

  logic [9:0] w_out;
  logic [5:0] w_cnt_nxt;
  logic [5:0] w_cnt6;
  logic [5:0] w_diff;
  logic       w_q8;

  // Stage-1 transition minimisation: pick XOR or XNOR chaining.
  always_comb begin
    w_n1d  = popcnt8(I_data);
    w_xnor = (w_n1d > 4'd4) ||
             ((w_n1d == 4'd4) && !I_data[0]);
    w_qm    = '0;
    w_qm[0] = I_data[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ I_data[i])
                       :  (w_qm[i-1] ^ I_data[i]);
    end
    w_qm[8] = ~w_xnor;
    w_n1q   = popcnt8(w_qm[7:0]);
  end

  // Stage-1 register: q_m, its counts and the side-band inputs.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_qm     <= '0;
      r_n1     <= '0;
      r_n0     <= '0;
      r_mode1  <= MODE_CTRL;
      r_ctrl1  <= 2'b00;
      r_terc41 <= '0;
    end else if (I_ce) begin
      r_qm     <= w_qm;
      r_n1     <= w_n1q;
      r_n0     <= 4'd8 - w_n1q;
      r_mode1  <= I_mode;
      r_ctrl1  <= I_ctrl;
      r_terc41 <= I_terc4;
    end
  end

  // Stage-2 DC balance and per-mode symbol selection.
  always_comb begin
    w_out     = CTRL_SYM_00;
    w_cnt_nxt = '0;
    w_cnt6    = {r_cnt[4], r_cnt};
    w_diff    = {2'b00, r_n1} - {2'b00, r_n0};
    w_q8      = r_qm[8];
    unique case (1'b1)
      (r_mode1 == MODE_VIDEO): begin
        if ((r_cnt == 5'd0) || (r_n1 == r_n0)) begin
          w_out = {~w_q8, w_q8,
                   w_q8 ? r_qm[7:0] : ~r_qm[7:0]};
          w_cnt_nxt = w_q8 ? (w_cnt6 + w_diff)
                           : (w_cnt6 - w_diff);
        end else if ((!r_cnt[4] && (r_n1 > r_n0)) ||
                     ( r_cnt[4] && (r_n0 > r_n1))) begin
          w_out     = {1'b1, w_q8, ~r_qm[7:0]};
          w_cnt_nxt = w_cnt6 + (w_q8 ? 6'd2 : 6'd0)
                      - w_diff;
        end else begin
          w_out     = {1'b0, w_q8, r_qm[7:0]};
          w_cnt_nxt = w_cnt6 + w_diff
                      - (w_q8 ? 6'd0 : 6'd2);
        end
      end
      (r_mode1 == MODE_VGUARD): begin
        w_out = LANE_GUARD;
      end
      (r_mode1 == MODE_DISLAND): begin
        w_out = terc4_sym(r_terc41);
      end
      (r_mode1 == MODE_DGUARD): begin
        w_out = (LANE_IDX == 0)
              ? terc4_sym({2'b11, r_ctrl1})
              : GUARD_ODD;
      end
      default: begin
        w_out = ctrl_sym(r_ctrl1);
      end
    endcase
  end

  // Stage-2 register: output symbol and running disparity.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_out <= CTRL_SYM_00;
      r_cnt <= '0;
    end else if (I_ce) begin
      r_out <= w_out;
      r_cnt <= w_cnt_nxt[4:0];
    end
  end

  assign O_tmds = r_out;

endmodule

// File: rtl/tmds_lane_encoder.sv
// Multi-lane TMDS encoder top.
// One independent tmds_lane per channel, sharing only the mode.
module tmds_lane_encoder
  import tmds_pkg::*;
#(
  parameter int CHANNELS = 3
) (
  input  logic                    I_clk,
  input  logic                    I_rst,
  input  logic                    I_ce,
  input  logic [2:0]              I_mode,
  input  logic [8*CHANNELS-1:0]   I_data,
  input  logic [2*CHANNELS-1:0]   I_ctrl,
  input  logic [4*CHANNELS-1:0]   I_terc4,
  output logic [10*CHANNELS-1:0]  O_tmds
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    tmds_lane #(
      .LANE_IDX (g)
    ) u_lane (
      .I_clk   (I_clk),
      .I_rst   (I_rst),
      .I_ce    (I_ce),
      .I_mode  (I_mode),
      .I_data  (I_data[8*g +: 8]),
      .I_ctrl  (I_ctrl[2*g +: 2]),
      .I_terc4 (I_terc4[4*g +: 4]),
      .O_tmds  (O_tmds[10*g +: 10])
    );
  end

endmodule

// File: tb/tb_tmds_lane_encoder.sv
// Directed bench for tmds_lane_encoder.
// Drives on the falling edge and checks on the falling edge.
module tb_tmds_lane_encoder;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [2:0]  mode;
  logic [23:0] data3;
  logic [5:0]  ctrl3;
  logic [11:0] terc3;
  logic [29:0] tmds3;
  logic [39:0] data5;
  logic [9:0]  ctrl5;
  logic [19:0] terc5;
  logic [49:0] tmds5;

  int n_tests = 0;
  int n_fail  = 0;

  tmds_lane_encoder #(.CHANNELS(3)) dut (
    .I_clk   (clk),
    .I_rst   (rst),
    .I_ce    (ce),
    .I_mode  (mode),
    .I_data  (data3),
    .I_ctrl  (ctrl3),
    .I_terc4 (terc3),
    .O_tmds  (tmds3)
  );

  tmds_lane_encoder #(.CHANNELS(5)) dut5 (
    .I_clk   (clk),
    .I_rst   (rst),
    .I_ce    (ce),
    .I_mode  (mode),
    .I_data  (data5),
    .I_ctrl  (ctrl5),
    .I_terc4 (terc5),
    .O_tmds  (tmds5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [9:0] obs,
                     input logic [9:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_lane(input int l,
                          input logic [7:0] d,
                          input logic [1:0] c,
                          input logic [3:0] t);
    if (l < 3) begin
      data3[8*l +: 8] = d;
      ctrl3[2*l +: 2] = c;
      terc3[4*l +: 4] = t;
    end
    data5[8*l +: 8] = d;
    ctrl5[2*l +: 2] = c;
    terc5[4*l +: 4] = t;
  endtask

  task automatic clear_in();
    for (int l = 0; l < 5; l++) set_lane(l, 8'h00, 2'b00, 4'h0);
  endtask

  function automatic logic [9:0] l3(input int i);
    return tmds3[10*i +: 10];
  endfunction

  function automatic logic [9:0] l5(input int i);
    return tmds5[10*i +: 10];
  endfunction

  initial begin
    rst   = 1'b1;
    ce    = 1'b1;
    mode  = 3'($urandom_range(0, 7));
    data3 = 24'($urandom);
    ctrl3 = 6'($urandom);
    terc3 = 12'($urandom);
    data5 = {8'($urandom), 32'($urandom)};
    ctrl5 = 10'($urandom);
    terc5 = 20'($urandom);
    #1;
    chk("rst_imm_l0", l3(0), 10'b1101010100);
    chk("rst_imm_l2", l3(2), 10'b1101010100);
    chk("rst_imm_5l4", l5(4), 10'b1101010100);
    cyc(3);
    chk("rst_hold_l1", l3(1), 10'b1101010100);

    rst  = 1'b0;
    mode = 3'd0;
    clear_in();
    cyc(2);
    chk("rst_post_l0", l3(0), 10'b1101010100);
    chk("rst_post_l1", l3(1), 10'b1101010100);

    set_lane(0, 8'h00, 2'b01, 4'h0);
    set_lane(2, 8'h00, 2'b11, 4'h0);
    cyc(1);
    chk("ctrl_lat1_l0", l3(0), 10'b1101010100);
    cyc(1);
    chk("ctrl01_l0", l3(0), 10'b0010101011);
    chk("ctrl00_l1", l3(1), 10'b1101010100);
    chk("ctrl11_l2", l3(2), 10'b1010101011);

    mode = 3'd2;
    cyc(2);
    chk("vg_l0", l3(0), 10'b1011001100);
    chk("vg_l1", l3(1), 10'b0100110011);
    chk("vg_l2", l3(2), 10'b1011001100);
    chk("vg5_l3", l5(3), 10'b0100110011);
    chk("vg5_l4", l5(4), 10'b1011001100);

    mode = 3'd4;
    set_lane(0, 8'h00, 2'b10, 4'h0);
    cyc(2);
    chk("dg_l0", l3(0), 10'b0101100011);
    chk("dg_l1", l3(1), 10'b0100110011);
    chk("dg_l2", l3(2), 10'b0100110011);

    mode = 3'd3;
    set_lane(0, 8'h00, 2'b00, 4'h9);
    set_lane(1, 8'h00, 2'b00, 4'h0);
    set_lane(2, 8'h00, 2'b00, 4'hF);
    cyc(2);
    chk("di_l0", l3(0), 10'b0100111001);
    chk("di_l1", l3(1), 10'b1010011100);
    chk("di_l2", l3(2), 10'b1011000011);

    mode = 3'd6;
    set_lane(0, 8'h00, 2'b01, 4'h0);
    cyc(2);
    chk("mode6_ctrl", l3(0), 10'b0010101011);

    rst = 1'b1;
    #1;
    chk("rst_mid", l3(0), 10'b1101010100);
    cyc(1);
    rst  = 1'b0;
    mode = 3'd1;
    set_lane(0, 8'h00, 2'b00, 4'h0);
    set_lane(1, 8'hFF, 2'b00, 4'h0);
    set_lane(2, 8'h01, 2'b00, 4'h0);
    cyc(2);
    chk("vid0_l0", l3(0), 10'b0100000000);
    chk("vid0_l1", l3(1), 10'b1000000000);
    chk("vid0_l2", l3(2), 10'b0111111111);
    cyc(1);
    chk("vid1_l0", l3(0), 10'b1111111111);
    chk("vid1_l1", l3(1), 10'b0011111111);
    chk("vid1_l2", l3(2), 10'b1100000000);
    cyc(1);
    chk("vid2_l0", l3(0), 10'b0100000000);
    chk("vid2_l1", l3(1), 10'b0011111111);
    chk("vid2_l2", l3(2), 10'b1100000000);

    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    chk("stall_s0", l3(0), 10'b0100000000);
    ce = 1'b0;
    cyc(1);
    chk("stall_h1", l3(0), 10'b0100000000);
    cyc(1);
    chk("stall_h2", l3(1), 10'b1000000000);
    cyc(1);
    chk("stall_h3", l3(0), 10'b0100000000);
    ce = 1'b1;
    cyc(1);
    chk("stall_s1", l3(0), 10'b1111111111);
    cyc(1);
    chk("stall_s2", l3(0), 10'b0100000000);
    chk("stall_s2_l1", l3(1), 10'b0011111111);
    cyc(1);
    chk("stall_s3", l3(0), 10'b1111111111);
    chk("stall_s3_l1", l3(1), 10'b1000000000);

    rst = 1'b1;
    cyc(1);
    rst  = 1'b0;
    clear_in();
    mode = 3'd1;
    cyc(1);
    mode = 3'd0;
    cyc(1);
    chk("clr_v0", l3(0), 10'b0100000000);
    mode = 3'd1;
    cyc(1);
    chk("clr_c", l3(0), 10'b1101010100);
    cyc(1);
    chk("clr_v1", l3(0), 10'b0100000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_lane_encoder.md
# tmds_lane_encoder

Parametrised multi-channel TMDS symbol encoder with pipelining and HDMI-style period modes. It sits between the video timing/pixel source and the 10:1 serialisers in the digital video output path. It converts per-channel 8-bit pixels, 2-bit control words or 4-bit TERC4 nibbles into 10-bit symbols with DC balancing. It is the successor to the fixed three-channel, video/control-only encoder: channel count is generic, there is a clock enable, and it adds guard-band and data-island (TERC4) modes.

## Interface
- CHANNELS, 3: number of TMDS lanes encoded in parallel (1..8).
- I_clk  in  1  pixel clock; all state updates on rising edge.
- I_rst  in  1  asynchronous, active-high reset.
- I_ce  in  1  clock enable; low freezes every register, including the disparity counters.
- I_mode  in  3  period mode, shared by all lanes: 0 CTRL, 1 VIDEO, 2 VGUARD, 3 DISLAND, 4 DGUARD; 5..7 behave as CTRL.
- I_data  in  8*CHANNELS  pixel byte; lane i occupies [8i+7:8i].
- I_ctrl  in  2*CHANNELS  control pair {c1,c0}; lane i occupies [2i+1:2i].
- I_terc4  in  4*CHANNELS  data-island nibble; lane i occupies [4i+3:4i].
- O_tmds  out  10*CHANNELS  symbol; lane i occupies [10i+9:10i]; bit 0 is serialised first.

## Operation
- Each lane is independent. The only shared input is I_mode. All modes traverse the same 2-stage pipeline.
- Stage 1 (VIDEO), with N1 = popcount(d):
  - If N1>4, or N1==4 with d[0]==0: use XNOR chaining, q_m[0]=d[0], q_m[i]=q_m[i-1] XNOR d[i], q_m[8]=0.
  - Otherwise: use XOR chaining with q_m[8]=1.
  - Registers q_m, its ones/zeros counts, the mode, and the ctrl/terc4 inputs.
- Stage 2 (VIDEO), with n1/n0 = ones/zeros of q_m[7:0] and signed 5-bit running disparity cnt:
  - If cnt==0 or n1==n0: out={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}; cnt += q_m[8]?(n1-n0):(n0-n1).
  - Else if (cnt>0 and n1>n0) or (cnt<0 and n0>n1): out={1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + (n0-n1).
  - Else: out={0, q_m[8], q_m[7:0]}; cnt += (n1-n0) - 2*(~q_m[8]).
- CTRL: ctrl 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011 (written as bits 9..0).
- VGUARD: even lanes 1011001100, odd lanes 0100110011.
- DISLAND: out=TERC4(terc4 nibble).
- DGUARD: lane 0 outputs TERC4({2'b11, ctrl[1:0]}); all other lanes output 0100110011.
- Disparity: cnt is cleared to 0 on every enabled cycle in which the stage-2 mode is not VIDEO. It is used and updated only in VIDEO. Its magnitude never exceeds 10, so 5 bits signed are sufficient.

## Timing
- Latency is exactly 2 enabled cycles from inputs to O_tmds, in every mode.
- Mode changes are pipeline-coherent: each symbol reflects the mode, data and ctrl sampled with it. Lanes never mix modes within one output word.
- I_ce low: the outputs hold their last value and no state advances. When I_ce returns high, the symbol sequence continues exactly as if the stall had not occurred.
- Reset: asynchronous. Both stages load mode CTRL with ctrl 00, and cnt=0. O_tmds for every lane is 1101010100 immediately. Reset asserted mid-frame discards in-flight symbols.
- Switching from VIDEO to any other mode and back: the first video symbol after the return is encoded with cnt=0.

## Structure
- Package tmds_pkg holds:
  - mode constants MODE_CTRL..MODE_DGUARD;
  - the four control symbols;
  - both guard patterns;
  - the 16-entry TERC4 table: 0:1010011100 1:1001100011 2:1011100100 3:1011100010 4:0101110001 5:0100011110 6:0110001110 7:0100111100 8:1011001100 9:0100111001 A:0110011100 B:1011000110 C:1010001110 D:1001110001 E:0101100011 F:1011000011.
- Sub-module tmds_lane is a single-lane, 2-stage encoder with a LANE_IDX parameter for guard selection. The top level is a generate loop of CHANNELS instances.

## Test plan
- Reset: assert I_rst with random inputs -> all lanes show 1101010100 immediately, and still show it 2 cycles after release when CTRL/00 is driven.
- CTRL: mode 0, lane 0 ctrl=01, lane 2 ctrl=11 -> 2 cycles later lane 0 shows 0010101011 and lane 2 shows 1010101011.
- VIDEO balance: from reset, drive 0x00 on lane 0 for 3 cycles -> outputs 0100000000, 1111111111, 0100000000 (cnt -8, +2, -6).
- Guards and TERC4: VGUARD -> lanes 0/1/2 show 1011001100 / 0100110011 / 1011001100. DGUARD with lane-0 ctrl=10 -> lane 0 shows 0101100011. DISLAND with nibble 0x9 -> 0100111001.
- CE stall: during the VIDEO 0x00 stream, drop I_ce for 3 cycles -> O_tmds is frozen, and the resumed sequence equals the unstalled reference.
- Disparity clear: VIDEO 0x00 ×1, then CTRL ×1, then VIDEO 0x00 -> the final video symbol is 0100000000 (cnt restarted from 0); with CHANNELS=5, lanes 3/4 under VGUARD show 0100110011 / 1011001100.
